// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler
// Shares one AES encipher core between NUM_REQ requesters. A round-robin
// arbiter picks a request, the FSM launches the core with an init pulse and
// steps the round counter and key index once per cycle. It then waits for done
// or a timeout and returns the tagged result on a valid/ready port.
//
// Handshake rule (request and response ports): a transfer happens on the
// rising edge where valid and ready are both high. The source keeps valid and
// its payload stable until that edge, and ready never depends on the other
// side's ready.
module aes_core_scheduler #(
    parameter int NUM_REQ      = 2,
    parameter int NUM_ROUNDS   = 10,
    parameter int DONE_TIMEOUT = 4,
    localparam int IDW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [NUM_REQ*128-1:0] i_req_plain,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic [127:0]           o_rsp_cipher,
    output logic [IDW-1:0]         o_rsp_id,
    output logic                   o_rsp_err,
    output logic                   o_core_init,
    output logic [127:0]           o_core_plain,
    output logic [3:0]             o_core_round,
    output logic [3:0]             o_key_idx,
    input  logic                   i_core_done,
    input  logic [127:0]           i_core_cipher,
    output logic [2:0]             o_dbg_state
);

    localparam int WCW = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand_idx;
    logic           grant_found;
    logic [3:0]     rnd;
    logic [WCW-1:0] wait_cnt;
    // Set once done has been captured; the following WAIT cycle hands over to RESP.
    logic           captured;

    assign o_dbg_state = state;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (int'(rr_ptr) + i >= NUM_REQ)
                cand_idx = IDW'(int'(rr_ptr) + i - NUM_REQ);
            else
                cand_idx = IDW'(int'(rr_ptr) + i);
            if (!grant_found && i_req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // One-hot accept strobe, only offered while idle.
    always_comb begin
        o_req_ready = '0;
        if (state == S_IDLE && grant_found)
            o_req_ready[grant_idx] = 1'b1;
    end

    // Job sequencer with registered core and response outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            rnd          <= '0;
            wait_cnt     <= '0;
            captured     <= 1'b0;
            o_rsp_valid  <= 1'b0;
            o_rsp_cipher <= '0;
            o_rsp_id     <= '0;
            o_rsp_err    <= 1'b0;
            o_core_init  <= 1'b0;
            o_core_plain <= '0;
            o_core_round <= '0;
            o_key_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        o_core_plain <= i_req_plain[int'(grant_idx)*128 +: 128];
                        o_rsp_id     <= grant_idx;
                        rr_ptr       <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDW'(1);
                        o_core_init  <= 1'b1;
                        o_core_round <= 4'd0;
                        o_key_idx    <= 4'd0;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    o_core_init  <= 1'b0;
                    rnd          <= 4'd1;
                    o_core_round <= 4'd1;
                    o_key_idx    <= 4'd1;
                    state        <= S_RUN;
                end
                S_RUN: begin
                    if (rnd == 4'(NUM_ROUNDS)) begin
                        // Round outputs stay at the last round through WAIT.
                        wait_cnt <= '0;
                        captured <= 1'b0;
                        state    <= S_WAIT;
                    end else begin
                        rnd          <= rnd + 4'd1;
                        o_core_round <= rnd + 4'd1;
                        o_key_idx    <= rnd + 4'd1;
                    end
                end
                S_WAIT: begin
                    if (captured) begin
                        o_rsp_valid  <= 1'b1;
                        o_core_round <= 4'd0;
                        o_key_idx    <= 4'd0;
                        state        <= S_RESP;
                    end else if (i_core_done) begin
                        o_rsp_cipher <= i_core_cipher;
                        o_rsp_err    <= 1'b0;
                        captured     <= 1'b1;
                    end else if (wait_cnt == WCW'(DONE_TIMEOUT - 1)) begin
                        o_rsp_cipher <= '0;
                        o_rsp_err    <= 1'b1;
                        o_rsp_valid  <= 1'b1;
                        o_core_round <= 4'd0;
                        o_key_idx    <= 4'd0;
                        state        <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        o_rsp_valid  <= 1'b0;
                        o_rsp_cipher <= '0;
                        o_rsp_err    <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: a stand-in encipher core answers each job,
// a round-robin reference model predicts grants, and each scenario task
// compares the observed response against the expected one.
module tb_aes_core_scheduler;

    localparam int NR   = 2;
    localparam int NRND = 10;
    localparam int DTO  = 4;
    localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*128-1:0] req_plain = '0;
    logic              rsp_ready = 1'b0;
    logic              core_done = 1'b0;
    logic [127:0]      core_cipher = '0;

    logic [NR-1:0]     o_req_ready;
    logic              o_rsp_valid;
    logic [127:0]      o_rsp_cipher;
    logic [0:0]        o_rsp_id;
    logic              o_rsp_err;
    logic              o_core_init;
    logic [127:0]      o_core_plain;
    logic [3:0]        o_core_round;
    logic [3:0]        o_key_idx;
    logic [2:0]        o_dbg_state;

    int checks = 0;
    int errors = 0;

    int           rr_ptr = 0;
    logic [127:0] pend_pt [NR];

    aes_core_scheduler #(.NUM_REQ(NR), .NUM_ROUNDS(NRND), .DONE_TIMEOUT(DTO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_plain(req_plain), .o_req_ready(o_req_ready),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_cipher(o_rsp_cipher),
        .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err),
        .o_core_init(o_core_init), .o_core_plain(o_core_plain),
        .o_core_round(o_core_round), .o_key_idx(o_key_idx),
        .i_core_done(core_done), .i_core_cipher(core_cipher),
        .o_dbg_state(o_dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Stand-in core: the real AES result for the known vector, otherwise a
    // fixed scramble of the plaintext it was handed.
    function automatic logic [127:0] fake_core(input logic [127:0] pt);
        if (pt == KAT_PT) return KAT_CT;
        return {pt[63:0], pt[127:64]} ^ 128'h5a5a_c3c3_0f0f_9696_a5a5_3c3c_f0f0_6969;
    endfunction

    // Reference arbiter: first pending requester at or after the pointer.
    function automatic int model_grant(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (v[(rr_ptr + i) % NR]) return (rr_ptr + i) % NR;
        end
        return -1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic present(input int k, input logic [127:0] pt);
        pend_pt[k] = pt;
        req_plain[k*128 +: 128] = pt;
        req_valid[k] = 1'b1;
    endtask

    // Driver: serve one job from grant to response handshake, recording what was seen.
    task automatic run_one(
        input  bit respond, input bit hold_valid, input int stall, input bit stray,
        output logic [NR-1:0] grant, output int waited, output int lat,
        output logic [127:0] got_ct, output int got_id, output bit got_err,
        output int ready_pulses, output bit seq_ok, output bit stable_ok, output bit timed_out);
        int n;
        bit found;
        grant = '0; waited = 0; lat = 0; got_ct = '0; got_id = -1; got_err = 1'b0;
        ready_pulses = 0; seq_ok = 1'b1; stable_ok = 1'b1; timed_out = 1'b0;
        rsp_ready = 1'b0; core_done = 1'b0; found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            #1;
            if (o_req_ready !== '0) begin
                grant = o_req_ready; waited = w; found = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!found) begin timed_out = 1'b1; return; end
        @(negedge clk);
        n = 1;
        if (!hold_valid) req_valid = req_valid & ~grant;
        while (n <= NRND + 1) begin
            if (o_core_init !== (n == 1)) seq_ok = 1'b0;
            if (o_core_round !== 4'(n - 1) || o_key_idx !== 4'(n - 1)) seq_ok = 1'b0;
            if (o_req_ready !== '0) ready_pulses++;
            core_done   = stray && (n == 5);
            core_cipher = (stray && n == 5) ? rand128() : '0;
            @(negedge clk);
            n++;
        end
        if (o_core_round !== 4'(NRND) || o_core_init !== 1'b0) seq_ok = 1'b0;
        core_done   = respond;
        core_cipher = respond ? fake_core(o_core_plain) : '0;
        found = 1'b0;
        for (int w = 0; w < 40 && !found; w++) begin
            if (o_rsp_valid === 1'b1) begin
                found = 1'b1;
            end else begin
                if (o_req_ready !== '0) ready_pulses++;
                @(negedge clk);
                n++;
                core_done = 1'b0;
                core_cipher = '0;
            end
        end
        if (!found) begin timed_out = 1'b1; return; end
        lat = n - 1;
        got_ct = o_rsp_cipher; got_id = int'(o_rsp_id); got_err = o_rsp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (o_rsp_valid !== 1'b1 || o_rsp_cipher !== got_ct || int'(o_rsp_id) != got_id || o_rsp_err !== got_err)
                stable_ok = 1'b0;
            if (o_req_ready !== '0) ready_pulses++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (o_rsp_valid !== 1'b0) stable_ok = 1'b0;
    endtask

    task automatic pulse_reset();
        req_valid = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rr_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        req_valid = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_dbg_state); end
        checks++; if ({o_core_init, o_core_round, o_key_idx} !== 9'd0) begin errors++; $display("FAIL reset_core_ctrl: got %h expected 0", {o_core_init, o_core_round, o_key_idx}); end
        checks++; if ({o_rsp_valid, o_rsp_id, o_rsp_err} !== 3'd0 || o_rsp_cipher !== '0) begin errors++; $display("FAIL reset_rsp: got v%b id%b e%b ct %h expected all 0", o_rsp_valid, o_rsp_id, o_rsp_err, o_rsp_cipher); end
        checks++; if (o_core_plain !== '0 || o_req_ready !== '0) begin errors++; $display("FAIL reset_plain_ready: got %h/%b expected 0", o_core_plain, o_req_ready); end
        rst = 1'b0;
        rr_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_kat();
        logic [NR-1:0] g; int wt, lat, id, rp; logic [127:0] ct; bit er, sq, st, to;
        present(0, KAT_PT);
        run_one(1'b1, 1'b0, 0, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL kat_timeout: got %b expected 0", to); end
        checks++; if (g !== 2'b01 || wt != 0) begin errors++; $display("FAIL kat_grant: got %b after %0d expected 01 after 0", g, wt); end
        checks++; if (sq !== 1'b1 || rp != 0) begin errors++; $display("FAIL kat_sequence: got seq_ok %b ready_pulses %0d expected 1/0", sq, rp); end
        checks++; if (lat != NRND + 3) begin errors++; $display("FAIL kat_latency: got %0d expected %0d", lat, NRND + 3); end
        checks++; if (ct !== KAT_CT || id != 0 || er !== 1'b0) begin errors++; $display("FAIL kat_rsp: got %h id %0d err %b expected %h id 0 err 0", ct, id, er, KAT_CT); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL kat_valid_clear: got %b expected 1", st); end
        rr_ptr = 1;
    endtask

    task automatic test_stall();
        logic [NR-1:0] g, eg; int wt, lat, id, rp, k; logic [127:0] ct; bit er, sq, st, to;
        present(0, rand128());
        present(1, rand128());
        for (int j = 0; j < 2; j++) begin
            k = model_grant(req_valid);
            eg = '0; eg[k] = 1'b1;
            run_one(1'b1, 1'b0, 5, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
            checks++; if (to !== 1'b0 || g !== eg) begin errors++; $display("FAIL stall_grant: got %b (timeout %b) expected %b", g, to, eg); end
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b expected 1", st); end
            checks++; if (rp != 0) begin errors++; $display("FAIL stall_no_ready: got %0d pulses expected 0", rp); end
            checks++; if (ct !== fake_core(pend_pt[k]) || id != k) begin errors++; $display("FAIL stall_rsp: got %h id %0d expected %h id %0d", ct, id, fake_core(pend_pt[k]), k); end
            rr_ptr = (k + 1) % NR;
        end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] g; int wt, lat, id, rp, k; logic [127:0] ct; bit er, sq, st, to;
        present(0, rand128());
        k = model_grant(req_valid);
        run_one(1'b0, 1'b0, 0, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL timeout_rsp_missing: got timeout %b expected 0", to); end
        checks++; if (er !== 1'b1 || ct !== '0 || id != k) begin errors++; $display("FAIL timeout_rsp: got err %b ct %h id %0d expected err 1 ct 0 id %0d", er, ct, id, k); end
        checks++; if (lat != NRND + 1 + DTO) begin errors++; $display("FAIL timeout_latency: got %0d expected %0d", lat, NRND + 1 + DTO); end
        rr_ptr = (k + 1) % NR;
    endtask

    task automatic test_random();
        logic [NR-1:0] g, eg; int wt, lat, id, rp, k, stall; logic [127:0] ct, ect; bit er, sq, st, to, respond, stray;
        for (int it = 0; it < 10; it++) begin
            for (int q = 0; q < NR; q++) begin
                if (!req_valid[q] && $urandom_range(0, 1) == 1) present(q, rand128());
            end
            if (req_valid == '0) present(int'($urandom_range(0, NR - 1)), rand128());
            k = model_grant(req_valid);
            eg = '0; eg[k] = 1'b1;
            respond = ($urandom_range(0, 3) != 0);
            stray = ($urandom_range(0, 1) == 1);
            stall = int'($urandom_range(0, 3));
            ect = respond ? fake_core(pend_pt[k]) : '0;
            run_one(respond, 1'b0, stall, stray, g, wt, lat, ct, id, er, rp, sq, st, to);
            checks++; if (to !== 1'b0 || g !== eg) begin errors++; $display("FAIL rand_grant[%0d]: got %b (timeout %b) expected %b", it, g, to, eg); end
            checks++; if (ct !== ect || id != k || er !== !respond) begin errors++; $display("FAIL rand_rsp[%0d]: got %h id %0d err %b expected %h id %0d err %b", it, ct, id, er, ect, k, !respond); end
            checks++; if (lat != (respond ? NRND + 3 : NRND + 1 + DTO) || sq !== 1'b1 || st !== 1'b1 || rp != 0) begin
                errors++; $display("FAIL rand_timing[%0d]: got lat %0d seq %b stable %b pulses %0d", it, lat, sq, st, rp);
            end
            rr_ptr = (k + 1) % NR;
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        logic [NR-1:0] g, eg; int wt, lat, id, rp, k; logic [127:0] ct; bit er, sq, st, to;
        pulse_reset();
        present(0, rand128());
        present(1, rand128());
        for (int j = 0; j < 4; j++) begin
            k = model_grant(req_valid);
            eg = '0; eg[k] = 1'b1;
            run_one(1'b1, 1'b1, 0, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
            checks++; if (to !== 1'b0 || g !== eg) begin errors++; $display("FAIL alt_grant[%0d]: got %b expected %b", j, g, eg); end
            checks++; if (ct !== fake_core(pend_pt[k]) || id != k) begin errors++; $display("FAIL alt_rsp[%0d]: got %h id %0d expected %h id %0d", j, ct, id, fake_core(pend_pt[k]), k); end
            rr_ptr = (k + 1) % NR;
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] g; int wt, lat, id, rp, seen; logic [127:0] ct; bit er, sq, st, to, found;
        present(1, rand128());
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
            #1;
            if (o_req_ready !== '0) found = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!found || o_req_ready !== 2'b10) begin errors++; $display("FAIL rmid_grant: got %b expected 10", o_req_ready); end
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        checks++; if (o_core_round !== 4'd5) begin errors++; $display("FAIL rmid_round: got %0d expected 5", o_core_round); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({o_core_init, o_core_round, o_key_idx, o_rsp_valid, o_rsp_err, o_rsp_id} !== 12'd0 || o_dbg_state !== 3'd0) begin
            errors++; $display("FAIL rmid_ctrl_zero: got init %b round %0d key %0d v %b e %b id %b st %0d expected 0", o_core_init, o_core_round, o_key_idx, o_rsp_valid, o_rsp_err, o_rsp_id, o_dbg_state);
        end
        checks++; if (o_rsp_cipher !== '0 || o_core_plain !== '0 || o_req_ready !== '0) begin errors++; $display("FAIL rmid_data_zero: got ct %h pt %h rdy %b expected 0", o_rsp_cipher, o_core_plain, o_req_ready); end
        rst = 1'b0;
        rr_ptr = 0;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            core_done = (c == 8);
            core_cipher = (c == 8) ? rand128() : '0;
            @(negedge clk);
            if (o_rsp_valid === 1'b1) seen++;
        end
        core_done = 1'b0;
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_rsp: got %0d valid cycles expected 0", seen); end
        present(1, rand128());
        run_one(1'b1, 1'b0, 0, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
        checks++; if (to !== 1'b0 || g !== 2'b10 || ct !== fake_core(pend_pt[1]) || id != 1 || er !== 1'b0) begin
            errors++; $display("FAIL rmid_recover: got g %b ct %h id %0d err %b expected 10 %h 1 0", g, ct, id, er, fake_core(pend_pt[1]));
        end
        rr_ptr = 0;
    endtask

    task automatic test_rr_skip();
        logic [NR-1:0] g; int wt, lat, id, rp; logic [127:0] ct; bit er, sq, st, to;
        present(1, rand128());
        run_one(1'b1, 1'b0, 0, 1'b0, g, wt, lat, ct, id, er, rp, sq, st, to);
        checks++; if (to !== 1'b0 || g !== 2'b10 || wt != 0) begin errors++; $display("FAIL rr_skip_grant: got %b after %0d expected 10 after 0", g, wt); end
        checks++; if (ct !== fake_core(pend_pt[1]) || id != 1) begin errors++; $display("FAIL rr_skip_rsp: got %h id %0d expected %h id 1", ct, id, fake_core(pend_pt[1])); end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_stall();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_rr_skip();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
